// File: rtl/hwpe_dma_loader.sv
// Byte-stream to 64-bit DMA write loader for the HWPE feature-map and kernel SRAMs.
// Packs 8 bytes little-endian per word and walks three address segments in order.
module hwpe_dma_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_seg0_base,
  input  logic [CNT_WIDTH-1:0]  cfg_seg0_words,
  input  logic [ADDR_WIDTH-1:0] cfg_seg1_base,
  input  logic [CNT_WIDTH-1:0]  cfg_seg1_words,
  input  logic [ADDR_WIDTH-1:0] cfg_seg2_base,
  input  logic [CNT_WIDTH-1:0]  cfg_seg2_words,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [7:0]            s_data,
  output logic                  dma_wen,
  output logic [ADDR_WIDTH-1:0] dma_wa,
  output logic [63:0]           dma_wd,
  output logic                  busy,
  output logic                  done,
  output logic                  fmap_done,
  output logic                  kernel_done
);

  typedef enum logic [2:0] {IDLE, SEG0, SEG1, SEG2, DONE} state_t;

  state_t                       state, state_next, target;
  logic [2:0][ADDR_WIDTH-1:0]   base_q;
  logic [2:0][CNT_WIDTH-1:0]    words_q;
  logic [2:0]                   byte_idx;
  logic [CNT_WIDTH-1:0]         word_cnt;
  logic [55:0]                  pack_q;
  logic [1:0]                   seg_sel;
  logic [ADDR_WIDTH-1:0]        cur_base;
  logic [CNT_WIDTH-1:0]         cur_words;
  logic [2:0]                   cfg_nz, q_nz;
  logic                         accept, word_end, seg_end, leave;
  logic                         fmap_set, kernel_set;

  // First segment at or after index 'from' with a nonzero word count, else DONE.
  function automatic state_t pick_next(input logic [1:0] from, input logic [2:0] nz);
    if (from == 2'd0 && nz[0])      return SEG0;
    else if (from <= 2'd1 && nz[1]) return SEG1;
    else if (from <= 2'd2 && nz[2]) return SEG2;
    else                            return DONE;
  endfunction

  assign cfg_nz = {cfg_seg2_words != '0, cfg_seg1_words != '0, cfg_seg0_words != '0};
  assign q_nz   = {words_q[2] != '0, words_q[1] != '0, words_q[0] != '0};

  assign seg_sel   = (state == SEG1) ? 2'd1 : (state == SEG2) ? 2'd2 : 2'd0;
  assign cur_base  = base_q[seg_sel];
  assign cur_words = words_q[seg_sel];

  assign s_ready  = (state == SEG0) || (state == SEG1) || (state == SEG2);
  assign busy     = (state != IDLE);
  assign accept   = s_valid && s_ready;
  assign word_end = accept && (byte_idx == 3'd7);
  assign seg_end  = word_end && (word_cnt == cur_words - CNT_WIDTH'(1));

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    target     = DONE;
    leave      = 1'b0;
    unique case (state)
      IDLE: if (start)   begin leave = 1'b1; target = pick_next(2'd0, cfg_nz); end
      SEG0: if (seg_end) begin leave = 1'b1; target = pick_next(2'd1, q_nz);   end
      SEG1: if (seg_end) begin leave = 1'b1; target = pick_next(2'd2, q_nz);   end
      SEG2: if (seg_end) begin leave = 1'b1; target = pick_next(2'd3, q_nz);   end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (leave) state_next = target;
  end

  // Crossing past SEG1 (by finishing it or skipping it) completes the feature map.
  assign fmap_set   = leave && (state != SEG2) && (target == SEG2 || target == DONE);
  assign kernel_set = leave && (target == DONE);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      base_q      <= '0;
      words_q     <= '0;
      byte_idx    <= '0;
      word_cnt    <= '0;
      pack_q      <= '0;
      dma_wen     <= 1'b0;
      dma_wa      <= '0;
      dma_wd      <= '0;
      done        <= 1'b0;
      fmap_done   <= 1'b0;
      kernel_done <= 1'b0;
    end else begin
      state   <= state_next;
      done    <= (state == DONE);
      dma_wen <= 1'b0;

      if (state == IDLE && start) begin
        base_q  <= {cfg_seg2_base, cfg_seg1_base, cfg_seg0_base};
        words_q <= {cfg_seg2_words, cfg_seg1_words, cfg_seg0_words};
      end

      if (fmap_set)                    fmap_done <= 1'b1;
      else if (state == IDLE && start) fmap_done <= 1'b0;
      if (kernel_set)                  kernel_done <= 1'b1;
      else if (state == IDLE && start) kernel_done <= 1'b0;

      if (accept) begin
        byte_idx <= byte_idx + 3'd1;
        for (int k = 0; k < 7; k++)
          if (byte_idx == 3'(k)) pack_q[8*k +: 8] <= s_data;
      end

      // Lane 7 bypasses the packing register straight into the outgoing word.
      if (word_end) begin
        dma_wen  <= 1'b1;
        dma_wd   <= {s_data, pack_q};
        dma_wa   <= cur_base + ADDR_WIDTH'({word_cnt, 3'b000});
        word_cnt <= seg_end ? '0 : word_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_hwpe_dma_loader.sv
// Self-checking bench for hwpe_dma_loader: a table of segment configurations with
// hand-computed write addresses, plus directed zero-count and reset-abort sequences.
module tb_hwpe_dma_loader;

  logic        clk, rst, start;
  logic [15:0] b0, b1, b2, w0, w1, w2;
  logic        s_valid, s_ready;
  logic [7:0]  s_data;
  logic        dma_wen;
  logic [15:0] dma_wa;
  logic [63:0] dma_wd;
  logic        busy, done, fmap_done, kernel_done;

  hwpe_dma_loader #(.ADDR_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_seg0_base(b0), .cfg_seg0_words(w0),
    .cfg_seg1_base(b1), .cfg_seg1_words(w1),
    .cfg_seg2_base(b2), .cfg_seg2_words(w2),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .dma_wen(dma_wen), .dma_wa(dma_wa), .dma_wd(dma_wd),
    .busy(busy), .done(done), .fmap_done(fmap_done), .kernel_done(kernel_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int          cyc;
    logic [15:0] wa;
    logic [63:0] wd;
    logic        fm;
    logic        kd;
  } wr_t;

  wr_t wq[$];
  int  dq[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (dma_wen) wq.push_back('{cyc: cyc, wa: dma_wa, wd: dma_wd, fm: fmap_done, kd: kernel_done});
      if (done) dq.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0]      b0, w0, b1, w1, b2, w2;
    bit               toggle;
    int               repulse_at;
    logic [7:0]       first;
    int               n_wr;
    logic [4:0][15:0] wa;
    int               fmap_idx;
    int               kern_idx;
  } vec_t;

  function automatic vec_t make_vec(
    input logic [15:0] vb0, vw0, vb1, vw1, vb2, vw2,
    input bit tog, input int rep, input logic [7:0] first, input int n,
    input logic [15:0] a0, a1, a2, a3, a4, input int fi, input int ki);
    vec_t v;
    v.b0 = vb0; v.w0 = vw0; v.b1 = vb1; v.w1 = vw1; v.b2 = vb2; v.w2 = vw2;
    v.toggle = tog; v.repulse_at = rep; v.first = first; v.n_wr = n;
    v.wa = {a4, a3, a2, a1, a0};
    v.fmap_idx = fi; v.kern_idx = ki;
    return v;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int   total, sent, guard, last_cyc;
    bit   acc, phase, repulsed, got_done;
    logic [63:0] exp_wd;
    wq.delete(); dq.delete();
    total = 8 * (int'(v.w0) + int'(v.w1) + int'(v.w2));
    @(posedge clk); #1;
    b0 = v.b0; w0 = v.w0; b1 = v.b1; w1 = v.w1; b2 = v.b2; w2 = v.w2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    sent = 0; guard = 0; phase = 1'b0; repulsed = 1'b0;
    while (sent < total && guard < 4000) begin
      s_valid = v.toggle ? !phase : 1'b1;
      s_data  = 8'(int'(v.first) + sent);
      if (sent == v.repulse_at && !repulsed) begin
        start = 1'b1; repulsed = 1'b1;
        b0 = 16'h7000; w0 = 16'd1; b1 = 16'h7100; w1 = 16'd3; b2 = 16'h7200; w2 = 16'd0;
      end
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) sent++;
      phase = !phase;
      guard++;
    end
    s_valid = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 300 && !got_done; i++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, " busy_after_done"}, 64'(busy), 64'd0);
    check({tag, " write_count"}, 64'(wq.size()), 64'(v.n_wr));
    for (int i = 0; i < v.n_wr && i < wq.size(); i++) begin
      for (int k = 0; k < 8; k++) exp_wd[8*k +: 8] = 8'(int'(v.first) + 8*i + k);
      check($sformatf("%s wa[%0d]", tag, i), 64'(wq[i].wa), 64'(v.wa[i]));
      check($sformatf("%s wd[%0d]", tag, i), wq[i].wd, exp_wd);
      check($sformatf("%s fmap_done@wr%0d", tag, i), 64'(wq[i].fm), 64'(i >= v.fmap_idx));
      check($sformatf("%s kernel_done@wr%0d", tag, i), 64'(wq[i].kd), 64'(i >= v.kern_idx));
      if (i > 0)
        check($sformatf("%s gap[%0d]", tag, i), 64'(wq[i].cyc - wq[i-1].cyc),
              v.toggle ? 64'd16 : 64'd8);
    end
    check({tag, " done_pulses"}, 64'(dq.size()), 64'd1);
    last_cyc = (wq.size() > 0) ? wq[wq.size()-1].cyc : -100;
    if (dq.size() > 0) check({tag, " done_timing"}, 64'(dq[0]), 64'(last_cyc + 1));
  endtask

  vec_t vecs[5];
  int   sc;
  bit   got;

  initial begin
    vecs[0] = make_vec(16'h0000, 16'd2, 16'h0800, 16'd2, 16'h1000, 16'd1, 1'b0, -1, 8'h00, 5,
                       16'h0000, 16'h0008, 16'h0800, 16'h0808, 16'h1000, 3, 4);
    vecs[1] = make_vec(16'h0000, 16'd2, 16'h0800, 16'd2, 16'h1000, 16'd1, 1'b1, -1, 8'h00, 5,
                       16'h0000, 16'h0008, 16'h0800, 16'h0808, 16'h1000, 3, 4);
    vecs[2] = make_vec(16'h0010, 16'd1, 16'h0800, 16'd0, 16'h1000, 16'd1, 1'b0, -1, 8'h30, 2,
                       16'h0010, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 0, 1);
    vecs[3] = make_vec(16'hFFF8, 16'd2, 16'h0800, 16'd0, 16'h1000, 16'd0, 1'b0, -1, 8'h80, 2,
                       16'hFFF8, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1);
    vecs[4] = make_vec(16'h0200, 16'd2, 16'h0300, 16'd1, 16'h0400, 16'd1, 1'b0, 4, 8'h60, 4,
                       16'h0200, 16'h0208, 16'h0300, 16'h0400, 16'h0000, 2, 3);

    rst = 1'b1; start = 1'b0; s_valid = 1'b1; s_data = 8'hEE;
    b0 = '0; b1 = '0; b2 = '0; w0 = '0; w1 = '0; w2 = '0;
    repeat (3) @(negedge clk);
    check("reset dma_wen", 64'(dma_wen), 64'd0);
    check("reset dma_wa", 64'(dma_wa), 64'd0);
    check("reset dma_wd", dma_wd, 64'd0);
    check("reset status", 64'({busy, done, fmap_done, kernel_done}), 64'd0);
    check("reset s_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("idle s_ready with s_valid", 64'(s_ready), 64'd0);
    check("idle busy", 64'(busy), 64'd0);
    s_valid = 1'b0;

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // All segments empty: straight to DONE, both status bits set, nothing written.
    wq.delete(); dq.delete();
    @(posedge clk); #1;
    b0 = 16'h0100; w0 = '0; b1 = 16'h0200; w1 = '0; b2 = 16'h0300; w2 = '0;
    start = 1'b1;
    sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero busy_in_done", 64'(busy), 64'd1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    @(posedge clk); #1;
    check("zero done_pulses", 64'(dq.size()), 64'd1);
    if (dq.size() > 0) check("zero done_timing", 64'(dq[0] - sc), 64'd2);
    check("zero writes", 64'(wq.size()), 64'd0);
    check("zero status", 64'({fmap_done, kernel_done}), 64'b11);

    // Abort a word after 5 bytes with reset; the next word must carry no stale lanes.
    wq.delete();
    b0 = 16'h0040; w0 = 16'd1; b1 = '0; w1 = '0; b2 = '0; w2 = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 8'(8'hA0 + i);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort dma_wa", 64'(dma_wa), 64'd0);
    check("abort dma_wd", dma_wd, 64'd0);
    check("abort status", 64'({busy, s_ready, dma_wen, fmap_done, kernel_done}), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    check("abort writes", 64'(wq.size()), 64'd0);
    run_vec("after_abort", make_vec(16'h0100, 16'd1, 16'h0000, 16'd0, 16'h0000, 16'd0, 1'b0, -1,
                                    8'h50, 1, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hwpe_dma_loader.md
Name: hwpe_dma_loader

Overview:
- Upstream loader that fills the HWPE feature-map and kernel SRAMs through the hwpe 64-bit DMA write port (dma_wen/dma_wa/dma_wd).
- Accepts a byte stream with a valid/ready handshake and packs 8 bytes little-endian into one 64-bit word.
- Issues one write per word across three configured segments, in order: fmap half 1, fmap half 2, kernel.
- Raises fmap_done and kernel_done status so the instruction sequencer can start issuing EAI instructions.

Parameters:
- ADDR_WIDTH, 16, width of dma_wa; matches `HWPE_ADDR_WIDTH.
- CNT_WIDTH, 16, width of the per-segment 64-bit word-count registers.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  single-cycle pulse; latches the cfg_* inputs and begins loading.
- cfg_seg0_base  input  ADDR_WIDTH  byte address of fmap half 1 (normally 0).
- cfg_seg0_words  input  CNT_WIDTH  64-bit words for fmap half 1.
- cfg_seg1_base  input  ADDR_WIDTH  byte address of fmap half 2 (`FMEM_ADDR2_START).
- cfg_seg1_words  input  CNT_WIDTH  64-bit words for fmap half 2.
- cfg_seg2_base  input  ADDR_WIDTH  byte address of the kernel region (`KMEM_ADDR_START).
- cfg_seg2_words  input  CNT_WIDTH  64-bit words for the kernel.
- s_valid  input  1  stream byte valid.
- s_ready  output  1  loader accepts a byte this cycle.
- s_data  input  8  stream byte.
- dma_wen  output  1  SRAM write strobe; one-cycle pulse per word.
- dma_wa  output  ADDR_WIDTH  SRAM byte address of the word.
- dma_wd  output  64  packed word; byte k of the word sits in bits [8k+7:8k].
- busy  output  1  high from the cycle after an accepted start through the DONE state.
- done  output  1  one-cycle pulse when all segments have completed.
- fmap_done  output  1  sticky; set when segment 1 completes.
- kernel_done  output  1  sticky; set when segment 2 completes.

Behaviour:
- Reset values: every output is 0, including dma_wa and dma_wd. FSM goes to IDLE, and the byte index, word counter and packing register clear.
- FSM states: IDLE, SEG0, SEG1, SEG2, DONE.
- IDLE:
  - s_ready=0.
  - On start, latch all cfg_*, clear fmap_done and kernel_done, then enter the first segment with a nonzero word count.
  - If all three counts are 0, go directly to DONE.
- SEGn:
  - s_ready=1, and dma_wen is only ever driven from these states.
  - Each cycle with s_valid&s_ready, place s_data in packing-register byte lane byte_idx, then byte_idx increments (3-bit, wraps 7->0).
  - When the byte with byte_idx=7 is accepted, the next cycle shows dma_wen=1, dma_wd = the full packed word (lane 7 = that byte), dma_wa = base + 8*word_cnt.
  - word_cnt increments on each write. Peak throughput is 1 byte/cycle, so 1 word per 8 cycles.
  - While s_valid=0, state and partial data hold.
- Segment end:
  - When the write of word cfg_segn_words-1 is issued, the FSM moves in the same edge to the next segment with a nonzero count, or to DONE. word_cnt resets to 0 and byte_idx is already 0.
  - Zero-count segments are skipped and their status still sets: fmap_done sets on leaving SEG1 or when SEG1 is skipped; kernel_done likewise for SEG2.
  - In the last write cycle of a segment, s_ready is already valid for the next segment, so no bubble is inserted.
- Status timing: fmap_done rises in the same cycle as the last seg1 dma_wen; kernel_done rises in the same cycle as the last seg2 dma_wen.
- DONE: done=1 for one cycle, s_ready=0, busy=1; next state is IDLE.
- start while busy is ignored, and the cfg_* inputs are not relatched.
- dma_wa arithmetic: base + (word_cnt<<3), truncated to ADDR_WIDTH. Wrap-around is silent with no error.
- dma_wd and dma_wa hold their last values when dma_wen=0.
- Reset mid-operation: the partial word is discarded, no write is issued, and all status clears.
- s_valid asserted in IDLE or DONE: the byte is not consumed (s_ready=0).

Test Plan:
- Reset then start with seg0=2@0x0000, seg1=2@0x0800, seg2=1@0x1000 and bytes 0x00..0x27 streamed continuously:
  - 5 writes total: wa=0x0000 wd=0x0706050403020100, wa=0x0008 wd=0x0F0E..08, wa=0x0800, wa=0x0808, wa=0x1000 wd=0x2726..20.
  - fmap_done rises with the 4th write, kernel_done with the 5th, done pulses 1 cycle later.
- Same configuration with s_valid toggled 1/0 every cycle: identical write sequence, with each write separated by 16 cycles.
- seg1_words=0, seg0=1, seg2=1: writes at seg0_base then seg2_base only; fmap_done sets with the first write.
- All word counts 0: done pulses 2 cycles after start, fmap_done=kernel_done=1, no dma_wen.
- rst asserted after 5 bytes of word 0, then a new start with seg0=1: the first write contains only the new 8 bytes (no stale lanes) at seg0_base.
- start re-pulsed mid-SEG0 with different cfg: ignored, and the original addresses and counts complete.
